// File: rtl/scs8hd_a311oi_vecgen_pkg.sv
// ============================================================================
// Module : scs8hd_vecgen_pkg
// Brief  : Shared FSM states, vector bit map and a311oi reference function.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package scs8hd_vecgen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int unsigned c_A1_BIT   = 0;
  localparam int unsigned c_A2_BIT   = 1;
  localparam int unsigned c_A3_BIT   = 2;
  localparam int unsigned c_B1_BIT   = 3;
  localparam int unsigned c_C1_BIT   = 4;
  localparam int unsigned c_NUM_VEC  = 32;
  localparam logic [4:0]  c_LAST_VEC = 5'(c_NUM_VEC - 1);
  localparam logic [4:0]  c_NO_FAIL  = 5'h1f;

  function automatic logic a311oi_exp(input logic [4:0] vec);
    return ~((vec[c_A1_BIT] & vec[c_A2_BIT] & vec[c_A3_BIT])
             | vec[c_B1_BIT] | vec[c_C1_BIT]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/scs8hd_a311oi_vecgen_if.sv
// ============================================================================
// Module : scs8hd_a311oi_vecgen_if
// Brief  : Cell-drive, cell-observe and result bundle of the a311oi exerciser.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface scs8hd_a311oi_vecgen_if #(
  parameter int unsigned CNT_W = 8
);
  logic             start;
  logic             Y_in;
  logic             A1;
  logic             A2;
  logic             A3;
  logic             B1;
  logic             C1;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_count;
  logic [4:0]       vec_idx;
  logic [4:0]       first_fail;

  modport master (
    input  start, Y_in,
    output A1, A2, A3, B1, C1, busy, done, pass, err_count, vec_idx, first_fail
  );

  modport slave (
    output start, Y_in,
    input  A1, A2, A3, B1, C1, busy, done, pass, err_count, vec_idx, first_fail
  );
endinterface

`default_nettype wire

// File: rtl/scs8hd_a311oi_vecgen_settle_cnt.sv
// ============================================================================
// Module : scs8hd_vecgen_settle_cnt
// Brief  : Loadable down-counter with zero flag; stops at zero.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module scs8hd_vecgen_settle_cnt #(
  parameter int unsigned W = 8
) (
  input  wire logic         CLK,
  input  wire logic         RESETB,
  input  wire logic         i_load,
  input  wire logic         i_dec,
  input  wire logic [W-1:0] i_load_val,
  output logic      [W-1:0] o_cnt,
  output logic              o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (!RESETB) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/scs8hd_a311oi_vecgen.sv
// ============================================================================
// Module : scs8hd_a311oi_vecgen
// Brief  : Sweeps all 32 a311oi input vectors, checks Y after a settle time.
//          SCS8HD_VECGEN_FIRSTFAIL_EN builds first-failing-vector capture.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module scs8hd_a311oi_vecgen
  import scs8hd_vecgen_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 8
) (
  input wire logic                CLK,
  input wire logic                RESETB,
  scs8hd_a311oi_vecgen_if.master  bus
);

  localparam int unsigned c_SET_W = 8;

  state_t           r_state;
  logic [4:0]       r_vec;
  logic [4:0]       r_drv;
  logic [CNT_W-1:0] r_err;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;

  logic [c_SET_W-1:0] w_cnt;
  logic               w_zero;
  logic               w_accept;
  logic               w_mis;
  logic               w_settle_last;
  logic [CNT_W-1:0]   w_err_next;

  scs8hd_vecgen_settle_cnt #(.W(c_SET_W)) u_settle (
    .CLK        (CLK),
    .RESETB     (RESETB),
    .i_load     (r_state == ST_DRIVE),
    .i_dec      (r_state == ST_SETTLE),
    .i_load_val (c_SET_W'(SETTLE_CYCLES)),
    .o_cnt      (w_cnt),
    .o_zero     (w_zero)
  );

  assign w_accept      = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && bus.start;
  // Four-state compare so an X/Z from the cell is flagged as a mismatch.
  assign w_mis         = (bus.Y_in !== a311oi_exp(r_vec));
  assign w_settle_last = (w_cnt == c_SET_W'(1)) || w_zero;
  assign w_err_next    = (w_mis && !(&r_err)) ? (r_err + CNT_W'(1)) : r_err;

  always_ff @(posedge CLK) begin
    if (!RESETB) begin
      r_state <= ST_IDLE;
      r_vec   <= '0;
      r_drv   <= '0;
      r_err   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            r_err   <= '0;
            r_vec   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_state <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          r_drv   <= r_vec;
          r_state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (w_settle_last) r_state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          r_err <= w_err_next;
          if (r_vec == c_LAST_VEC) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == '0);
            r_state <= ST_DONE;
          end else begin
            r_vec   <= r_vec + 5'd1;
            r_state <= ST_DRIVE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef SCS8HD_VECGEN_FIRSTFAIL_EN
  logic [4:0] r_ff;

  // An empty error count marks the first mismatch of the sweep.
  always_ff @(posedge CLK) begin
    if (!RESETB || w_accept) begin
      r_ff <= c_NO_FAIL;
    end else if ((r_state == ST_SAMPLE) && w_mis && (r_err == '0)) begin
      r_ff <= r_vec;
    end
  end

  assign bus.first_fail = r_ff;
`else
  assign bus.first_fail = c_NO_FAIL;
`endif

  assign bus.A1        = r_drv[c_A1_BIT];
  assign bus.A2        = r_drv[c_A2_BIT];
  assign bus.A3        = r_drv[c_A3_BIT];
  assign bus.B1        = r_drv[c_B1_BIT];
  assign bus.C1        = r_drv[c_C1_BIT];
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.pass      = r_pass;
  assign bus.err_count = r_err;
  assign bus.vec_idx   = r_vec;

endmodule

`default_nettype wire
